shreg_xfer_arbiter: RTL

// - Shares one 4-bit serial-in shift register (shr/shr_in/Q datapath) between two requesters, A and B.
// - Arbitrates round-robin, captures the winner's parallel word and sequences it serially, LSB first.
// - Drives shr for exactly WIDTH cycles, so the word lands in the shift register with Q[0]=d[0].
// - Sits between the requesters and the shift-register instance; it owns that instance's shr and shr_in pins.

---
 rtl/shreg_ctrl_pkg.sv | 15 +
 rtl/shreg_xfer_arbiter_rr_arb2.sv | 33 +++
 rtl/shreg_xfer_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/shreg_ctrl_pkg.sv
// Shared definitions for the shift-register transfer arbiter.
package shreg_ctrl_pkg;

  // Controller states: wait for a request, stream the word, optional idle gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Owner / pointer codes for the two requesters.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/shreg_xfer_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational pick, registered fairness pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] win
);
  import shreg_ctrl_pkg::*;

  logic ptr;
  logic ptr_next;

  // Lone requester always wins; on a tie the pointer decides.
  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (ptr == OWN_B) ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
    // After a grant the pointer favours the requester that just lost.
    ptr_next = adv ? win[0] : ptr;
  end

  // Fairness pointer; starts favouring A.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) ptr <= OWN_A;
    else      ptr <= ptr_next;
  end

endmodule

// File: rtl/shreg_xfer_arbiter.sv
// Arbitrates two requesters onto one serial-in shift register and streams
// the winning word LSB first, counting completed transfers.
module shreg_xfer_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             shr,
  output logic             shr_in,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic [CNTW-1:0]  xfer_cnt
);
  import shreg_ctrl_pkg::*;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             gnt_a_n, gnt_b_n, shr_n, shr_in_n, busy_n, owner_n, done_n;
  logic [CNTW-1:0]  xfer_cnt_n;
  logic [1:0]       win;
  logic             adv, arb_ok;
  logic [WIDTH-1:0] word;

  rr_arb2 u_arb (
    .clk (clk),
    .clr (clr),
    .req ({req_b, req_a}),
    .adv (adv),
    .win (win)
  );

  // Next-state and next-output logic; a grant may coincide with the end of a
  // transfer when there is no gap, so arbitration is applied last.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n    = state;
    shadow_n   = shadow;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    gnt_a_n    = 1'b0;
    gnt_b_n    = 1'b0;
    done_n     = 1'b0;
    shr_n      = shr;
    shr_in_n   = shr_in;
    busy_n     = busy;
    owner_n    = owner;
    xfer_cnt_n = xfer_cnt;
    arb_ok     = 1'b0;
    adv        = 1'b0;
    word       = win[1] ? data_b : data_a;

    unique case (state)
      ST_IDLE: arb_ok = 1'b1;
      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          shr_n      = 1'b0;
          shr_in_n   = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          xfer_cnt_n = xfer_cnt + CNTW'(1);
          if (GAP == 0) begin
            state_n = ST_IDLE;
            arb_ok  = 1'b1;
          end else begin
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
          shr_in_n  = shadow[bit_cnt + BW'(1)];
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          arb_ok  = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (arb_ok && (req_a || req_b)) begin
      adv       = 1'b1;
      shadow_n  = word;
      gnt_a_n   = win[0];
      gnt_b_n   = win[1];
      owner_n   = win[1] ? OWN_B : OWN_A;
      busy_n    = 1'b1;
      shr_n     = 1'b1;
      shr_in_n  = word[0];
      bit_cnt_n = '0;
      state_n   = ST_SHIFT;
    end
  end

  // State, datapath and registered outputs; clr abandons any transfer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      shr      <= 1'b0;
      shr_in   <= 1'b0;
      busy     <= 1'b0;
      owner    <= OWN_A;
      done     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      shadow   <= shadow_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      gnt_a    <= gnt_a_n;
      gnt_b    <= gnt_b_n;
      shr      <= shr_n;
      shr_in   <= shr_in_n;
      busy     <= busy_n;
      owner    <= owner_n;
      done     <= done_n;
      xfer_cnt <= xfer_cnt_n;
    end
  end

endmodule
